// File: rtl/itf_bus_arbiter.sv
// Round-robin arbiter granting one client at a time onto a shared 8-bit addr/data bus.
// A grant lasts until the owner signals last, reaches MAX_BEATS, or drops its request.
module itf_bus_arbiter #(
  parameter int NUM_CLI   = 4,
  parameter int MAX_BEATS = 4,
  localparam int IDX_W    = (NUM_CLI > 1) ? $clog2(NUM_CLI) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CLI-1:0]   req,
  input  logic [NUM_CLI-1:0]   last,
  input  logic [8*NUM_CLI-1:0] cli_addr,
  input  logic [8*NUM_CLI-1:0] cli_data,
  output logic [NUM_CLI-1:0]   gnt,
  output logic                 bus_valid,
  input  logic                 bus_ready,
  output logic [7:0]           bus_addr,
  output logic [7:0]           bus_data,
  output logic                 busy,
  output logic [1:0]           dbg_state,
  output logic [3:0]           dbg_beat_cnt,
  output logic [IDX_W-1:0]     dbg_rr_ptr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_CLI-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   ptr_after;
  int                 scan;

  // Scan clients starting at the round-robin pointer, wrapping at NUM_CLI.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    cand       = '0;
    for (int k = 0; k < NUM_CLI; k++) begin
      scan = int'(ptr_q) + k;
      if (scan >= NUM_CLI) scan = scan - NUM_CLI;
      cand = IDX_W'(scan);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign ptr_after = (idx_q == IDX_W'(NUM_CLI - 1)) ? '0 : idx_q + IDX_W'(1);

  // Handshake: a beat moves on a posedge where bus_valid && bus_ready; the
  // owner holds addr/data stable while bus_ready is low, with no timeout.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWN;
          gnt_d   = {{(NUM_CLI-1){1'b0}}, 1'b1} << pick_idx;
          idx_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (!req[idx_q]) begin
          state_d = GAP;
          gnt_d   = '0;
          ptr_d   = ptr_after;
        end else if (bus_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (last[idx_q] || cnt_d == 4'(MAX_BEATS)) begin
            state_d = GAP;
            gnt_d   = '0;
            ptr_d   = ptr_after;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign busy         = (state_q != IDLE);
  assign bus_valid    = (state_q == OWN) && req[idx_q];
  assign bus_addr     = (state_q == OWN) ? cli_addr[8*idx_q +: 8] : 8'h00;
  assign bus_data     = (state_q == OWN) ? cli_data[8*idx_q +: 8] : 8'h00;
  assign dbg_state    = state_q;
  assign dbg_beat_cnt = cnt_q;
  assign dbg_rr_ptr   = ptr_q;

endmodule

// File: tb/tb_itf_bus_arbiter.sv
// Bench for itf_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural ownership model.
module tb_itf_bus_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   last = '0;
  logic [8*N-1:0] cli_addr = '0;
  logic [8*N-1:0] cli_data = '0;
  logic           bus_ready = 1'b0;
  logic [N-1:0]   gnt;
  logic           bus_valid;
  logic [7:0]     bus_addr;
  logic [7:0]     bus_data;
  logic           busy;
  logic [1:0]     dbg_state;
  logic [3:0]     dbg_beat_cnt;
  logic [1:0]     dbg_rr_ptr;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];
  bit cmp_en = 1'b0;

  itf_bus_arbiter #(.NUM_CLI(N), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .cli_addr(cli_addr), .cli_data(cli_data),
    .gnt(gnt), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_addr(bus_addr), .bus_data(bus_data), .busy(busy),
    .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner < 0 means nobody holds the bus; gap marks the dead cycle after a release.
  typedef struct {
    int owner;
    int beats;
    int ptr;
    bit gap;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t s, logic [N-1:0] rq, logic [N-1:0] lst, logic rdy);
    model_t n = s;
    if (s.gap) begin
      n.gap = 1'b0;
    end else if (s.owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (s.ptr + k) % N;
        if (n.owner < 0 && rq[c]) begin
          n.owner = c;
          n.beats = 0;
        end
      end
    end else if (!rq[s.owner]) begin
      n.ptr   = (s.owner + 1) % N;
      n.owner = -1;
      n.gap   = 1'b1;
    end else if (rdy) begin
      n.beats = s.beats + 1;
      if (lst[s.owner] || n.beats == MB) begin
        n.ptr   = (s.owner + 1) % N;
        n.owner = -1;
        n.gap   = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '{owner: -1, beats: 0, ptr: 0, gap: 1'b0};
    else      m <= model_next(m, req, last, bus_ready);
  end

  function automatic logic [N-1:0] f_gnt(model_t s);
    return (s.owner < 0) ? '0 : (N'(1) << s.owner);
  endfunction

  function automatic logic [7:0] f_byte(model_t s, logic [8*N-1:0] v);
    return (s.owner < 0) ? 8'h00 : v[8*s.owner +: 8];
  endfunction

  function automatic logic f_valid(model_t s, logic [N-1:0] rq);
    return (s.owner >= 0) && rq[s.owner];
  endfunction

  // Per-cycle comparison, sampled 1ns after the falling edge.
  always @(negedge clk) begin
    #1;
    if (cmp_en) begin
      chk("m_gnt",      32'(gnt),          32'(f_gnt(m)));
      chk("m_valid",    32'(bus_valid),    32'(f_valid(m, req)));
      chk("m_addr",     32'(bus_addr),     32'(f_byte(m, cli_addr)));
      chk("m_data",     32'(bus_data),     32'(f_byte(m, cli_data)));
      chk("m_busy",     32'(busy),         32'((m.owner >= 0) || m.gap));
      chk("m_beat_cnt", 32'(dbg_beat_cnt), 32'(m.beats));
      chk("m_rr_ptr",   32'(dbg_rr_ptr),   32'(m.ptr));
      chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
      last[i] = ($urandom_range(0, 3) == 0);
    end
    bus_ready = ($urandom_range(0, 3) != 0);
    cli_addr  = 32'($urandom);
    cli_data  = 32'($urandom);
  endtask

  task automatic rr_sweep();
    logic [N-1:0] prev;
    logic [N-1:0] e;
    int own_len;
    int low_len;
    int owners;
    prev    = '0;
    own_len = 0;
    low_len = 0;
    owners  = 0;
    exp_q   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req       = 4'b1111;
    last      = '0;
    bus_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (gnt != '0 && prev == '0) begin
        e = exp_q.pop_front();
        chk("rr_order", 32'(gnt), 32'(e));
        if (owners > 0) chk("rr_low_cycles", 32'(low_len), 32'd2);
        owners++;
        own_len = 0;
      end
      if (gnt != '0) own_len++;
      if (gnt == '0 && prev != '0) begin
        chk("rr_own_len", 32'(own_len), 32'(MB));
        low_len = 0;
      end
      if (gnt == '0) low_len++;
      prev = gnt;
    end
    chk("rr_done", 32'(exp_q.size()), 32'd0);
    req = '0;
    repeat (8) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_gnt",    32'(gnt),        32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_valid",  32'(bus_valid),  32'd0);
    chk("rst_addr",   32'(bus_addr),   32'd0);
    chk("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);

    // Single client, two beats ending with last; grant on first edge after release.
    req = 4'b0001; cli_addr = 32'h0000_0010; cli_data = 32'h0000_00A5;
    last = '0; bus_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("d1_gnt",   32'(gnt),      32'h1);
    chk("d1_addr",  32'(bus_addr), 32'h10);
    chk("d1_data",  32'(bus_data), 32'hA5);
    @(posedge clk); #1 last = 4'b0001;
    @(negedge clk);
    chk("d1_beat1", 32'(dbg_beat_cnt), 32'd1);
    @(posedge clk); #1 begin req = '0; last = '0; end
    @(negedge clk);
    chk("d1_gap_gnt",  32'(gnt),        32'd0);
    chk("d1_gap_busy", 32'(busy),       32'd1);
    chk("d1_rr_ptr",   32'(dbg_rr_ptr), 32'd1);
    @(negedge clk);
    chk("d1_idle_busy", 32'(busy), 32'd0);

    // Pointer at 1: client 2 wins over client 0, then client 0.
    req = 4'b0101; last = 4'b0101;
    @(posedge clk); @(negedge clk);
    chk("d2_first", 32'(gnt), 32'h4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("d2_second", 32'(gnt), 32'h1);
    req = '0; last = '0;
    repeat (3) @(negedge clk);

    // Stall with bus_ready low: valid held, no beats counted.
    req = 4'b0001; bus_ready = 1'b0; cli_addr = 32'h0000_0033;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("d3_stall_valid", 32'(bus_valid),    32'd1);
      chk("d3_stall_cnt",   32'(dbg_beat_cnt), 32'd0);
    end
    bus_ready = 1'b1;
    @(negedge clk);
    chk("d3_resume_cnt", 32'(dbg_beat_cnt), 32'd1);
    req = '0;
    repeat (3) @(negedge clk);

    // Owner 2 aborts after one beat.
    req = 4'b0100;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("d4_gap_busy", 32'(busy),         32'd1);
    chk("d4_gap_gnt",  32'(gnt),          32'd0);
    chk("d4_rr_ptr",   32'(dbg_rr_ptr),   32'd3);
    chk("d4_cnt",      32'(dbg_beat_cnt), 32'd1);
    repeat (2) @(negedge clk);

    // Reset in the middle of an ownership.
    req = 4'b0010;
    @(posedge clk); @(negedge clk);
    chk("d5_gnt", 32'(gnt), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("d5_rst_gnt",   32'(gnt),       32'd0);
    chk("d5_rst_valid", 32'(bus_valid), 32'd0);
    chk("d5_rst_busy",  32'(busy),      32'd0);
    req = 4'b1000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("d5_after_gnt", 32'(gnt),        32'h8);
    chk("d5_after_ptr", 32'(dbg_rr_ptr), 32'd0);
    req = '0;
    repeat (3) @(negedge clk);

    // Full-load rotation from pointer 0 (pointer returned to 0 by owner 3).
    rr_sweep();

    // Randomized traffic with occasional reset pulses.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      drive_random();
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    @(negedge clk); #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/itf_bus_arbiter.md
ITF_BUS_ARBITER -- requirements
Module: itf_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLI, default 4, number of requesting clients (2..8).
REQ-002 SHALL have parameter MAX_BEATS, default 4, max beats per grant (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (negedge rst).
REQ-005 SHALL have port req  input  NUM_CLI  per-client bus request, level.
REQ-006 SHALL have port last  input  NUM_CLI  per-client final-beat flag, sampled on a transferring beat.
REQ-007 SHALL have port cli_addr  input  8*NUM_CLI  client i address in bits [8i+7:8i].
REQ-008 SHALL have port cli_data  input  8*NUM_CLI  client i data in bits [8i+7:8i].
REQ-009 SHALL have port gnt  output  NUM_CLI  registered one-hot grant; zero when no owner.
REQ-010 SHALL have port bus_valid  output  1  shared bus beat valid.
REQ-011 SHALL have port bus_ready  input  1  shared bus sink accepts beat.
REQ-012 SHALL have port bus_addr  output  8  shared bus address.
REQ-013 SHALL have port bus_data  output  8  shared bus data.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, OWN, GAP.
REQ-016 In IDLE with any req set, SHALL at next posedge set gnt to the first requester at or above rr_ptr (wrapping modulo NUM_CLI), enter OWN, clear beat_cnt.
REQ-017 In IDLE with req==0, SHALL remain in IDLE with gnt==0.
REQ-018 Request-to-grant latency SHALL be exactly 1 cycle from IDLE.
REQ-019 In OWN, bus_valid SHALL equal req[g] (g = granted index), combinationally.
REQ-020 In OWN, bus_addr/bus_data SHALL combinationally reflect cli_addr/cli_data of g; outside OWN SHALL be 8'h00.
REQ-021 A beat SHALL transfer on a posedge where bus_valid && bus_ready; beat_cnt (4-bit) SHALL increment per beat.
REQ-022 OWN SHALL end (-> GAP, gnt<=0) on a transferring beat with last[g]==1, or on the beat making beat_cnt==MAX_BEATS.
REQ-023 OWN SHALL end (-> GAP) when req[g]==0 at a posedge (abort); no beat transfers that cycle.
REQ-024 On leaving OWN, rr_ptr SHALL be set to (g+1) modulo NUM_CLI.
REQ-025 GAP SHALL last exactly 1 cycle with gnt==0, bus_valid==0, then return to IDLE.
REQ-026 req changes of non-owners during OWN/GAP SHALL not affect the current grant.
REQ-027 bus_ready held low in OWN SHALL stall indefinitely with addr/data held by client; no timeout.
REQ-028 gnt SHALL never have more than one bit set.

Reset
REQ-029 On rst low, SHALL asynchronously force state IDLE, gnt 0, rr_ptr 0, beat_cnt 0, busy 0, bus_valid 0, bus_addr/bus_data 8'h00.
REQ-030 Reset mid-OWN SHALL drop the grant immediately with no further beat; first arbitration after release SHALL start from rr_ptr 0.
REQ-031 First arbitration SHALL occur on the first posedge after rst deasserts.

Verification
REQ-032 req=4'b0001, addr 8'h10/data 8'hA5, last on beat 2, bus_ready=1 -> gnt=0001 cycle 1; 2 beats with 10/A5; GAP; IDLE; rr_ptr=1.
REQ-033 req=4'b1111 held, never last, bus_ready=1 -> grants 0001,0010,0100,1000,0001; each 4 beats; 1 GAP cycle between owners.
REQ-034 req=4'b0101, rr_ptr=1 -> gnt=0100 first, then 0001.
REQ-035 Owner 0 granted, bus_ready=0 for 5 cycles then 1 -> bus_valid=1 with beat_cnt 0 throughout stall; beats resume.
REQ-036 Owner 2 drops req after 1 beat -> GAP next cycle, rr_ptr=3, beat count not incremented on abort cycle.
REQ-037 rst pulsed low mid-OWN -> gnt=0, bus_valid=0 immediately; after release req=1000 -> gnt=1000 after 1 cycle.
